pipeline_hazard_controller: RTL
===============================

Name: pipeline_hazard_controller

Overview:
Central stall/flush sequencer for the RV32IM 5-stage pipeline. It consumes the taken-branch decision and target from the branch control unit in EX, plus load-use, multi-cycle MUL/DIV and instruction-memory-busy conditions. It drives PC redirect/enable and the IF/ID, ID/EX and EX hold/flush controls. It also keeps redirect and stall performance counters.

Parameters:
MULDIV_CYCLES, 4, total cycles a MUL/DIV instruction occupies EX (legal range 1 to 2^CNT_WIDTH-1)
CNT_WIDTH, 32, width of the performance counters

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET  input  1  synchronous, active-high reset
BRANCH_SELECT  input  1  taken branch/jump in EX (from branch control unit)
TARGET_ADDRESS  input  32  branch/jump target from branch control unit
ID_EX_MEM_READ  input  1  instruction in EX is a load
ID_EX_RD  input  5  destination register of instruction in EX
IF_ID_RS1  input  5  rs1 of instruction in ID
IF_ID_RS2  input  5  rs2 of instruction in ID
MULDIV_START  input  1  M-extension instruction entered EX this cycle
IMEM_BUSY  input  1  instruction memory cannot deliver or accept a new PC this cycle
PC_WRITE_EN  output  1  PC register update enable
PC_SELECT  output  1  1 = load PC_TARGET, 0 = PC+4
PC_TARGET  output  32  redirect address
IF_ID_WRITE_EN  output  1  IF/ID register enable
IF_ID_FLUSH  output  1  load bubble into IF/ID
ID_EX_FLUSH  output  1  load bubble into ID/EX
EX_STALL  output  1  hold ID/EX and EX stage contents
REDIRECT_COUNT  output  CNT_WIDTH  accepted redirects since reset
STALL_COUNT  output  CNT_WIDTH  cycles with PC_WRITE_EN=0 since reset

Behaviour:
- States: RUN, MD_WAIT, REDIRECT. Registers: state, md_cnt (CNT_WIDTH), tgt_q (32), both counters.
- RESET (synchronous, overrides everything): next state RUN, md_cnt=0, tgt_q=0, counters=0. While RESET=1 the outputs are forced: PC_WRITE_EN=0, PC_SELECT=0, PC_TARGET=0, IF_ID_WRITE_EN=0, IF_ID_FLUSH=1, ID_EX_FLUSH=1, EX_STALL=0. Reset mid-MD_WAIT or mid-REDIRECT abandons the operation.
- Default outputs (RUN, no event): PC_WRITE_EN=1, PC_SELECT=0, IF_ID_WRITE_EN=1, flushes=0, EX_STALL=0, PC_TARGET=tgt_q.
- Target alignment: PC_TARGET is always {addr[31:1],1'b0}, using TARGET_ADDRESS or tgt_q.
- RUN priority order, highest first: BRANCH_SELECT > MULDIV_START > load-use > IMEM_BUSY.
- RUN + BRANCH_SELECT:
  - IF_ID_FLUSH=1 and ID_EX_FLUSH=1, combinational, same cycle.
  - If IMEM_BUSY=0: PC_SELECT=1, PC_TARGET=aligned TARGET_ADDRESS, PC_WRITE_EN=1, stay RUN. Redirect latency is 0 cycles.
  - If IMEM_BUSY=1: PC_WRITE_EN=0, tgt_q<=aligned TARGET_ADDRESS, go to REDIRECT.
  - REDIRECT_COUNT increments once per branch.
  - If MULDIV_START is asserted in the same cycle, it is dropped.
- REDIRECT:
  - IF_ID_FLUSH=1, ID_EX_FLUSH=1, PC_SELECT=1, PC_TARGET=tgt_q, PC_WRITE_EN=!IMEM_BUSY.
  - Return to RUN in the cycle IMEM_BUSY=0.
  - BRANCH_SELECT, MULDIV_START and load-use are ignored (wrong path).
- RUN + MULDIV_START:
  - If MULDIV_CYCLES=1: no stall.
  - Else, same cycle: PC_WRITE_EN=0, IF_ID_WRITE_EN=0, EX_STALL=1, and md_cnt<=MULDIV_CYCLES-1, go to MD_WAIT.
- MD_WAIT:
  - md_cnt decrements each cycle.
  - While md_cnt>1: same stall outputs as the MULDIV_START cycle.
  - At md_cnt==1: stalls released, go to RUN.
  - Net effect: MULDIV_CYCLES-1 stall cycles; the instruction occupies EX for MULDIV_CYCLES cycles.
  - BRANCH_SELECT is ignored.
- Load-use (RUN only): condition is ID_EX_MEM_READ && ID_EX_RD!=0 && (ID_EX_RD==IF_ID_RS1 || ID_EX_RD==IF_ID_RS2). Response: PC_WRITE_EN=0, IF_ID_WRITE_EN=0, ID_EX_FLUSH=1 for exactly one cycle.
- IMEM_BUSY alone (RUN): PC_WRITE_EN=0, IF_ID_FLUSH=1 (bubble into ID); ID/EX advances normally.
- STALL_COUNT increments every non-reset cycle with PC_WRITE_EN=0. Both counters wrap modulo 2^CNT_WIDTH.

Decomposition:
- Shared package pipeline_ctrl_pkg holds the state encoding constants (RUN=2'd0, MD_WAIT=2'd1, REDIRECT=2'd2) and the default MULDIV_CYCLES.
- One natural sub-module: hazard_perf_counters (the two wrapping counters with synchronous clear).
- The FSM and output decode stay in the top module.

Test Plan:
- Reset held 3 cycles with BRANCH_SELECT=1, TARGET_ADDRESS=32'h40 -> PC_WRITE_EN=0, both flushes=1, counters 0; first post-reset cycle shows default RUN outputs.
- BRANCH_SELECT=1, TARGET_ADDRESS=32'h00000021, IMEM_BUSY=0 -> same cycle PC_SELECT=1, PC_TARGET=32'h20, both flushes=1; REDIRECT_COUNT=1.
- BRANCH_SELECT=1, TARGET_ADDRESS=32'h80, IMEM_BUSY=1 for 3 cycles -> PC_WRITE_EN=0 for 3 cycles with flushes held; 4th cycle PC_WRITE_EN=1, PC_TARGET=32'h80; STALL_COUNT=3.
- MULDIV_START=1 with MULDIV_CYCLES=4 -> EX_STALL=1 for exactly 3 cycles, RUN on 4th cycle; MULDIV_START+BRANCH_SELECT together -> redirect only, no EX_STALL.
- ID_EX_MEM_READ=1, ID_EX_RD=5, IF_ID_RS2=5 -> one-cycle stall plus ID_EX_FLUSH; same stimulus with ID_EX_RD=0 -> no stall.
- Reset asserted at md_cnt=2 in MD_WAIT -> next cycle RUN, EX_STALL=0, counters 0.

Source files
------------

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds the FSM state encoding, the default MUL/DIV latency and the target alignment helper.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_WAIT  = 2'd1,
    REDIRECT = 2'd2
  } hz_state_t;

  localparam int unsigned MULDIV_CYCLES_DEFAULT = 4;

  // Instruction fetch addresses are halfword aligned; bit 0 is always cleared.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFE;
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_perf_counters.sv
// Redirect and stall performance counters.
// Both counters wrap naturally and clear synchronously.
module hazard_perf_counters #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 redirect_inc,
  input  logic                 stall_inc,
  output logic [CNT_WIDTH-1:0] redirect_count,
  output logic [CNT_WIDTH-1:0] stall_count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      redirect_count <= '0;
      stall_count    <= '0;
    end else begin
      if (redirect_inc) redirect_count <= redirect_count + CNT_WIDTH'(1);
      if (stall_inc)    stall_count    <= stall_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: branch redirect, MUL/DIV hold,
// load-use interlock and instruction-memory back-pressure, plus performance counters.
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MULDIV_CYCLES = MULDIV_CYCLES_DEFAULT,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 BRANCH_SELECT,
  input  logic [31:0]          TARGET_ADDRESS,
  input  logic                 ID_EX_MEM_READ,
  input  logic [4:0]           ID_EX_RD,
  input  logic [4:0]           IF_ID_RS1,
  input  logic [4:0]           IF_ID_RS2,
  input  logic                 MULDIV_START,
  input  logic                 IMEM_BUSY,
  output logic                 PC_WRITE_EN,
  output logic                 PC_SELECT,
  output logic [31:0]          PC_TARGET,
  output logic                 IF_ID_WRITE_EN,
  output logic                 IF_ID_FLUSH,
  output logic                 ID_EX_FLUSH,
  output logic                 EX_STALL,
  output logic [CNT_WIDTH-1:0] REDIRECT_COUNT,
  output logic [CNT_WIDTH-1:0] STALL_COUNT
);

  hz_state_t            state, state_next;
  logic [CNT_WIDTH-1:0] md_cnt, md_cnt_next;
  logic [31:0]          tgt_q, tgt_next;
  logic                 redirect_inc;
  logic                 load_use;

  assign load_use = ID_EX_MEM_READ && (ID_EX_RD != 5'd0) &&
                    ((ID_EX_RD == IF_ID_RS1) || (ID_EX_RD == IF_ID_RS2));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= RUN;
      md_cnt <= '0;
      tgt_q  <= '0;
    end else begin
      state  <= state_next;
      md_cnt <= md_cnt_next;
      tgt_q  <= tgt_next;
    end
  end

  always_comb begin
    state_next     = state;
    md_cnt_next    = md_cnt;
    tgt_next       = tgt_q;
    redirect_inc   = 1'b0;
    PC_WRITE_EN    = 1'b1;
    PC_SELECT      = 1'b0;
    PC_TARGET      = align_pc(tgt_q);
    IF_ID_WRITE_EN = 1'b1;
    IF_ID_FLUSH    = 1'b0;
    ID_EX_FLUSH    = 1'b0;
    EX_STALL       = 1'b0;

    unique case (state)
      RUN: begin
        if (BRANCH_SELECT) begin
          IF_ID_FLUSH  = 1'b1;
          ID_EX_FLUSH  = 1'b1;
          redirect_inc = 1'b1;
          if (!IMEM_BUSY) begin
            PC_SELECT = 1'b1;
            PC_TARGET = align_pc(TARGET_ADDRESS);
          end else begin
            PC_WRITE_EN = 1'b0;
            tgt_next    = align_pc(TARGET_ADDRESS);
            state_next  = REDIRECT;
          end
        end else if (MULDIV_START) begin
          if (MULDIV_CYCLES > 1) begin
            PC_WRITE_EN    = 1'b0;
            IF_ID_WRITE_EN = 1'b0;
            EX_STALL       = 1'b1;
            md_cnt_next    = CNT_WIDTH'(MULDIV_CYCLES - 1);
            state_next     = MD_WAIT;
          end
        end else if (load_use) begin
          PC_WRITE_EN    = 1'b0;
          IF_ID_WRITE_EN = 1'b0;
          ID_EX_FLUSH    = 1'b1;
        end else if (IMEM_BUSY) begin
          PC_WRITE_EN = 1'b0;
          IF_ID_FLUSH = 1'b1;
        end
      end

      MD_WAIT: begin
        md_cnt_next = md_cnt - CNT_WIDTH'(1);
        if (md_cnt > CNT_WIDTH'(1)) begin
          PC_WRITE_EN    = 1'b0;
          IF_ID_WRITE_EN = 1'b0;
          EX_STALL       = 1'b1;
        end else begin
          state_next = RUN;
        end
      end

      REDIRECT: begin
        IF_ID_FLUSH = 1'b1;
        ID_EX_FLUSH = 1'b1;
        PC_SELECT   = 1'b1;
        PC_WRITE_EN = !IMEM_BUSY;
        if (!IMEM_BUSY) state_next = RUN;
      end

      default: state_next = RUN;
    endcase

    if (RESET) begin
      PC_WRITE_EN    = 1'b0;
      PC_SELECT      = 1'b0;
      PC_TARGET      = '0;
      IF_ID_WRITE_EN = 1'b0;
      IF_ID_FLUSH    = 1'b1;
      ID_EX_FLUSH    = 1'b1;
      EX_STALL       = 1'b0;
      redirect_inc   = 1'b0;
    end
  end

  hazard_perf_counters #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_perf (
    .clk           (CLK),
    .clr           (RESET),
    .redirect_inc  (redirect_inc),
    .stall_inc     (!RESET && !PC_WRITE_EN),
    .redirect_count(REDIRECT_COUNT),
    .stall_count   (STALL_COUNT)
  );

endmodule
